// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall, branch flush and HALT drain sequencing for a 5-stage pipeline
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_IFID,
    input  logic [2:0]  Rs_IFID,
    input  logic [2:0]  Rt_IFID,
    input  logic        useRs_IFID,
    input  logic        useRt_IFID,
    input  logic        RegWrite_ID,
    input  logic [2:0]  WrR_ID,
    input  logic        halt_ID,
    input  logic        takeBranch_EXMEM,
    output logic        stall,
    output logic        bubble_IDEX,
    output logic        flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic        err
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t      r_state, w_next;
    logic        r_sb0_v, r_sb1_v;
    logic [2:0]  r_sb0_r, r_sb1_r;
    logic [1:0]  r_drain_cnt, w_drain_nxt;
    logic [1:0]  r_hz_run;
    logic        w_hz, w_hz_stall;
    // Decode-stage source matches against EX (sb0) and MEM (sb1) producers
    always_comb begin
        w_hz = valid_IFID & ((useRs_IFID & ((r_sb0_v & r_sb0_r == Rs_IFID) | (r_sb1_v & r_sb1_r == Rs_IFID)))
                           | (useRt_IFID & ((r_sb0_v & r_sb0_r == Rt_IFID) | (r_sb1_v & r_sb1_r == Rt_IFID))));
        w_hz_stall = (r_state == RUN) & ~takeBranch_EXMEM & w_hz;
    end
    // Next state and pipeline controls; branch beats hazard beats HALT, all muted in reset
    always_comb begin
        w_next      = r_state;
        w_drain_nxt = r_drain_cnt;
        stall       = 1'b0;
        bubble_IDEX = 1'b0;
        flush       = 1'b0;
        case (r_state)
            RUN: begin
                if (takeBranch_EXMEM) begin
                    flush       = 1'b1;
                    bubble_IDEX = 1'b1;
                end else if (w_hz) begin
                    stall       = 1'b1;
                    bubble_IDEX = 1'b1;
                end else if (valid_IFID & halt_ID) begin
                    stall       = 1'b1;
                    bubble_IDEX = 1'b1;
                    w_next      = DRAIN;
                    w_drain_nxt = 2'd2;
                end
            end
            DRAIN: begin
                stall       = 1'b1;
                bubble_IDEX = 1'b1;
                if (takeBranch_EXMEM) begin
                    flush       = 1'b1;
                    w_next      = RUN;
                    w_drain_nxt = 2'd0;
                end else if (r_drain_cnt == 2'd0) begin
                    w_next = HALTED;
                end else begin
                    w_drain_nxt = r_drain_cnt - 2'd1;
                end
            end
            default: begin
                stall       = 1'b1;
                bubble_IDEX = 1'b1;
            end
        endcase
        if (rst) begin
            stall       = 1'b0;
            bubble_IDEX = 1'b0;
            flush       = 1'b0;
        end
    end
    // State, scoreboard, stall counter and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_drain_cnt <= 2'd0;
            r_sb0_v     <= 1'b0;
            r_sb0_r     <= 3'd0;
            r_sb1_v     <= 1'b0;
            r_sb1_r     <= 3'd0;
            r_hz_run    <= 2'd0;
            stall_cnt   <= 16'd0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_drain_cnt <= w_drain_nxt;
            r_sb1_v     <= takeBranch_EXMEM ? 1'b0 : r_sb0_v;
            r_sb1_r     <= takeBranch_EXMEM ? 3'd0 : r_sb0_r;
            r_sb0_v     <= bubble_IDEX ? 1'b0 : valid_IFID & RegWrite_ID;
            r_sb0_r     <= bubble_IDEX ? 3'd0 : WrR_ID;
            r_hz_run    <= w_hz_stall ? (r_hz_run == 2'd2 ? 2'd2 : r_hz_run + 2'd1) : 2'd0;
            if (w_hz_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            err <= err | (w_hz_stall & r_hz_run == 2'd2) | (r_state == HALTED & halt_ID & takeBranch_EXMEM);
        end
    end
    assign halted = (r_state == HALTED);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed per-cycle vector table plus HALTED, error and reset sequences
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst, valid_IFID, useRs_IFID, useRt_IFID, RegWrite_ID, halt_ID, takeBranch_EXMEM;
    logic [2:0]  Rs_IFID, Rt_IFID, WrR_ID;
    logic        stall, bubble_IDEX, flush, halted, err;
    logic [15:0] stall_cnt;
    int          checks = 0;
    int          failures = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .valid_IFID(valid_IFID), .Rs_IFID(Rs_IFID), .Rt_IFID(Rt_IFID),
        .useRs_IFID(useRs_IFID), .useRt_IFID(useRt_IFID), .RegWrite_ID(RegWrite_ID), .WrR_ID(WrR_ID),
        .halt_ID(halt_ID), .takeBranch_EXMEM(takeBranch_EXMEM), .stall(stall), .bubble_IDEX(bubble_IDEX),
        .flush(flush), .halted(halted), .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v;
        logic [2:0]  rs, rt;
        logic        urs, urt, rw;
        logic [2:0]  wr;
        logic        halt, br, st, bu, fl, ha;
        logic [15:0] cnt;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int v, int rs, int rt, int urs, int urt, int rw, int wr,
                                int halt, int br, int st, int bu, int fl, int ha, int cnt, int er);
        vec_t x;
        x.rst = 1'(r);   x.v = 1'(v);     x.rs = 3'(rs);    x.rt = 3'(rt);
        x.urs = 1'(urs); x.urt = 1'(urt); x.rw = 1'(rw);    x.wr = 3'(wr);
        x.halt = 1'(halt); x.br = 1'(br); x.st = 1'(st);    x.bu = 1'(bu);
        x.fl = 1'(fl);   x.ha = 1'(ha);   x.cnt = 16'(cnt); x.er = 1'(er);
        return x;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; valid_IFID = x.v; Rs_IFID = x.rs; Rt_IFID = x.rt;
        useRs_IFID = x.urs; useRt_IFID = x.urt; RegWrite_ID = x.rw; WrR_ID = x.wr;
        halt_ID = x.halt; takeBranch_EXMEM = x.br;
    endtask

    task automatic check_all(input int row, input vec_t x);
        chk("stall", row, 16'(stall), 16'(x.st));
        chk("bubble_IDEX", row, 16'(bubble_IDEX), 16'(x.bu));
        chk("flush", row, 16'(flush), 16'(x.fl));
        chk("halted", row, 16'(halted), 16'(x.ha));
        chk("stall_cnt", row, stall_cnt, x.cnt);
        chk("err", row, 16'(err), 16'(x.er));
    endtask

    initial begin
        logic exp_err;
        vec_t x;
        // reset with branch/halt asserted: controls forced low
        vecs.push_back(mk(1,1,0,0,0,0,0,0,1,1, 0,0,0,0,0,0));
        // RAW on EX producer: ADD r3 then reader of r3 -> 2 stalls
        vecs.push_back(mk(0,1,0,0,0,0,1,3,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0, 1,1,0,0,0,0));
        vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0, 1,1,0,0,1,0));
        vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0, 0,0,0,0,2,0));
        // RAW on MEM producer via Rt -> 1 stall
        vecs.push_back(mk(0,1,0,0,0,0,1,5,0,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,1,1,0,1,0,0,0,0,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,1,0,5,0,1,0,0,0,0, 1,1,0,0,2,0));
        vecs.push_back(mk(0,1,0,5,0,1,0,0,0,0, 0,0,0,0,3,0));
        // r5 named in Rt but not read -> no stall in EX or MEM position
        vecs.push_back(mk(0,1,0,0,0,0,1,5,0,0, 0,0,0,0,3,0));
        vecs.push_back(mk(0,1,0,5,0,0,0,0,0,0, 0,0,0,0,3,0));
        vecs.push_back(mk(0,1,0,5,0,0,0,0,0,0, 0,0,0,0,3,0));
        // branch during hazard on r4: flush wins, wrong-path entry dropped
        vecs.push_back(mk(0,1,0,0,0,0,1,4,0,0, 0,0,0,0,3,0));
        vecs.push_back(mk(0,1,4,0,1,0,0,0,0,1, 0,1,1,0,3,0));
        vecs.push_back(mk(0,1,4,0,1,0,0,0,0,0, 0,0,0,0,3,0));
        // wrong-path HALT: branch one cycle later returns to RUN
        vecs.push_back(mk(0,1,0,0,0,0,0,0,1,0, 1,1,0,0,3,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1, 1,1,1,0,3,0));
        vecs.push_back(mk(0,1,0,0,0,0,1,2,0,0, 0,0,0,0,3,0));
        vecs.push_back(mk(0,1,2,0,1,0,0,0,0,0, 1,1,0,0,3,0));
        vecs.push_back(mk(0,1,2,0,1,0,0,0,0,0, 1,1,0,0,4,0));
        vecs.push_back(mk(0,1,2,0,1,0,0,0,0,0, 0,0,0,0,5,0));
        // reset during the second stall cycle
        vecs.push_back(mk(0,1,0,0,0,0,1,3,0,0, 0,0,0,0,5,0));
        vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0, 1,1,0,0,5,0));
        vecs.push_back(mk(1,1,3,0,1,0,0,0,0,0, 0,0,0,0,6,0));
        vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0, 0,0,0,0,0,0));
        // HALT with empty pipeline: halted after the 4th edge
        vecs.push_back(mk(0,1,0,0,0,0,0,0,1,0, 1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0));

        drive(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_all(i, vecs[i]);
        end

        // HALTED: random inputs ignored; err follows halt&branch coincidence
        exp_err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            x = mk(0, int'($urandom_range(0,1)), int'($urandom_range(0,7)), int'($urandom_range(0,7)),
                   int'($urandom_range(0,1)), int'($urandom_range(0,1)), int'($urandom_range(0,1)),
                   int'($urandom_range(0,7)), int'($urandom_range(0,1)), int'($urandom_range(0,1)),
                   1,1,0,1,0,0);
            x.er = exp_err;
            drive(x);
            #1;
            check_all(100 + c, x);
            exp_err = exp_err | (x.halt & x.br);
        end

        // deterministic err: halt and branch together in HALTED
        @(negedge clk);
        drive(mk(0,0,0,0,0,0,0,0,1,1, 0,0,0,0,0,0));
        #1;
        chk("halted_hold", 200, 16'(halted), 16'd1);
        @(negedge clk);
        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        #1;
        chk("err_set", 201, 16'(err), 16'd1);
        chk("halted_sticky", 201, 16'(halted), 16'd1);

        // reset clears halted and err; block runs normally again
        @(negedge clk);
        drive(mk(1,1,0,0,0,0,0,0,1,1, 0,0,0,0,0,0));
        #1;
        chk("rst_stall", 202, 16'(stall), 16'd0);
        chk("rst_flush", 202, 16'(flush), 16'd0);
        @(negedge clk);
        drive(mk(0,1,0,0,0,0,1,7,0,0, 0,0,0,0,0,0));
        #1;
        chk("post_rst_halted", 203, 16'(halted), 16'd0);
        chk("post_rst_err", 203, 16'(err), 16'd0);
        chk("post_rst_stall", 203, 16'(stall), 16'd0);
        @(negedge clk);
        drive(mk(0,1,0,7,0,1,0,0,0,0, 0,0,0,0,0,0));
        #1;
        chk("post_rst_hz", 204, 16'(stall), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB; no forwarding). It tracks destination registers of in-flight instructions in a small scoreboard, stalls IF/ID and injects ID/EX bubbles on RAW hazards, and flushes wrong-path instructions when the execute stage reports a taken branch. It also sequences HALT: it drains the pipeline before asserting a sticky `halted`. It sits beside the decode and execute stages and drives the enables and flush controls of the PC, IF/ID and ID/EX registers.

## Interface
- No parameters; register address width fixed at 3 bits (8 GPRs).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_IFID` in 1: IF/ID holds a real instruction (0 = bubble).
- `Rs_IFID`, `Rt_IFID` in 3 each: source register numbers of the instruction in decode.
- `useRs_IFID`, `useRt_IFID` in 1 each: the instruction reads Rs / Rt.
- `RegWrite_ID` in 1: the decode instruction writes the register file.
- `WrR_ID` in 3: destination register of the decode instruction.
- `halt_ID` in 1: the decode instruction is HALT.
- `takeBranch_EXMEM` in 1: registered taken-branch/jump indication from execute. The redirect PC is being loaded this cycle.
- `stall` out 1: hold PC and IF/ID (enable low).
- `bubble_IDEX` out 1: load a NOP (all control zero) into ID/EX this cycle.
- `flush` out 1: squash IF/ID contents (load bubble).
- `halted` out 1: pipeline drained after HALT; sticky until reset.
- `stall_cnt` out 16: saturating count of hazard-stall cycles.
- `err` out 1: sticky protocol error.

## Operation
- Scoreboard has two entries, each {v, reg[2:0]}:
  - `sb0`: the instruction now in EX.
  - `sb1`: the instruction now in MEM.
- The register file is write-through, so the WB stage is not tracked.
- Per-cycle scoreboard update:
  - `sb1 <= takeBranch_EXMEM ? 0 : sb0`.
  - `sb0 <= bubble_IDEX ? 0 : {valid_IFID & RegWrite_ID, WrR_ID}`.
- Hazard term: `hz = valid_IFID & ((useRs_IFID & (M(Rs_IFID))) | (useRt_IFID & M(Rt_IFID)))`, where `M(r) = (sb0.v & sb0.reg==r) | (sb1.v & sb1.reg==r)`.
- FSM states: RUN, DRAIN, HALTED.
- RUN, checked in priority order:
  1. `takeBranch_EXMEM`: `flush=1`, `bubble_IDEX=1`, `stall=0`. Stay in RUN.
  2. `hz`: `stall=1`, `bubble_IDEX=1`, `flush=0`, `stall_cnt++` (saturates at 16'hFFFF).
  3. `valid_IFID & halt_ID`: go to DRAIN with `drain_cnt=2`. The HALT itself enters ID/EX as a bubble (`bubble_IDEX=1`, `stall=1`).
  4. Otherwise all three controls are 0.
- DRAIN:
  - `stall=1` and `bubble_IDEX=1` every cycle.
  - If `takeBranch_EXMEM`: the HALT was wrong-path. Assert `flush=1`, return to RUN, clear `drain_cnt`.
  - Else if `drain_cnt==0`: go to HALTED.
  - Else `drain_cnt--`.
- HALTED:
  - `halted=1`, `stall=1`, `bubble_IDEX=1`; `flush=0`.
  - All inputs are ignored until `rst`.
- `err` sets, and stays set until `rst`, in either case:
  - `hz` has been true for 3 consecutive stall cycles (a stall can legally last at most 2 cycles).
  - `halt_ID` and `takeBranch_EXMEM` are both high while in HALTED.

## Timing
- `stall`, `bubble_IDEX` and `flush` are combinational from the inputs, the scoreboard and the FSM state. Inputs must be stable before the edge.
- `halted`, `stall_cnt`, `err`, the scoreboard and `drain_cnt` are registered.
- While `rst` is high, `stall`, `bubble_IDEX` and `flush` are forced to 0.
- After reset edge: scoreboard entries invalid, state RUN, `halted=0`, `stall_cnt=0`, `err=0`.
- Reset mid-stall or mid-drain aborts the sequence; the block returns to RUN with an empty scoreboard.
- Stall latency:
  - Dependence on the EX producer: 2 stall cycles.
  - Dependence on the MEM producer: 1 stall cycle.
  - The consumer leaves ID on the cycle after `hz` falls.
- Branch and hazard in the same cycle: flush wins. `stall=0`, `stall_cnt` is not incremented, and the wrong-path `sb0` entry is dropped on the next edge.
- `halted` rises exactly 4 edges after the HALT is in ID with no stall or flush (1 edge to enter DRAIN, then 3 DRAIN cycles).
- Register 0 is an ordinary register, with no special-case zero handling.

## Test plan
- **RAW on EX producer**: decode `ADD r3` (RegWrite_ID=1, WrR_ID=3), then decode an instruction with `Rs_IFID=3`, `useRs_IFID=1`.
  - Required: `stall=1` and `bubble_IDEX=1` for exactly 2 cycles, then 0.
  - Required: `stall_cnt=2`.
- **RAW on MEM producer**: a producer of r5, then an independent instruction, then a consumer of r5 via Rt.
  - Required: exactly 1 stall cycle.
  - Required: a consumer of r5 that does not assert `useRt_IFID` gives 0 stall cycles.
- **Branch flush**: `takeBranch_EXMEM=1` while `hz=1` and `sb0={1,3'd4}`.
  - Required: `flush=1`, `bubble_IDEX=1`, `stall=0`.
  - Required: next cycle `sb1.v=0`, and a consumer of r4 does not stall.
- **HALT drain**: `halt_ID=1` with the pipeline empty.
  - Required: `stall=1` from that cycle onward.
  - Required: `halted` rises on the 4th edge and stays high for 20 further cycles, with all inputs toggled randomly.
- **Wrong-path HALT**: `halt_ID=1`, then `takeBranch_EXMEM=1` 1 cycle later.
  - Required: `flush=1`, state returns to RUN, `halted` stays 0, and normal stalls resume.
- **Reset mid-stall**: assert `rst` during the second stall cycle.
  - Required: `stall`, `bubble_IDEX` and `flush` are 0 during reset.
  - Required: after the edge, `stall_cnt=0`, `err=0`, and a pending consumer of r3 does not stall.
